// File: rtl/display_scan_ctrl_pkg.sv
// rtl/display_scan_ctrl_pkg.sv - shared types, constants and hex decode for display blocks
//
// Purpose : scan FSM state type, blanking constants, and the hex-to-segment
//           decoder shared by the seven-segment display blocks.
// Contents: scan_state_t, SEG_BLANK, AN_OFF, hex_to_seg()
package display_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  // Active-low: all segments dark, all anodes off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_tick.sv
// rtl/display_scan_ctrl_tick.sv - scan-rate divider producing the per-digit dwell tick
//
// Purpose: free-running 0..DIV-1 counter; tick is high for the one cycle
//          the count sits at DIV-1 while enabled.
// Ports  : clk_in (clock), rst (sync active-low reset), clr (sync clear),
//          en (count enable), tick (dwell tick, one cycle per DIV)
module scan_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // At least 17 bits so the board configuration (DIV=100000) always fits.
  localparam int CW = ($clog2(DIV) > 17) ? $clog2(DIV) : 17;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit common-anode seven-segment scan controller
//
// Purpose: time-multiplexes four hex digits onto one seven-segment display,
//          inserting an all-off blanking gap before every digit to avoid ghosting.
// Ports  : clk_in (board clock), rst (sync active-low reset), en (display enable),
//          hex_in (four nibbles, digit 0 rightmost), dp_in (decimal points, 1=lit),
//          digit_en (per-digit show mask), an/seg/dp (active-low display pins,
//          registered), active_digit (digit slot currently scheduled)
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int SCAN_HZ      = 500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] hex_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  active_digit
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int BW  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  scan_state_t   state;
  logic [BW-1:0] blank_cnt;
  logic          tick;
  logic          div_run;

  // The divider only runs while scanning; it is held cleared in IDLE so the
  // first slot after enable/reset is a full DIV cycles long.
  assign div_run = en && (state != ST_IDLE);

  scan_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (!div_run),
    .en     (div_run),
    .tick   (tick)
  );

  always_ff @(posedge clk_in) begin
    if (!rst || !en) begin
      state        <= ST_IDLE;
      blank_cnt    <= '0;
      active_digit <= '0;
      an           <= AN_OFF;
      seg          <= SEG_BLANK;
      dp           <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state        <= ST_BLANK;
          blank_cnt    <= '0;
          active_digit <= '0;
        end
        ST_BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            // The output registers are the snapshot: inputs are sampled once
            // here and held for the whole drive phase, so no mid-dwell tearing.
            state     <= ST_DRIVE;
            blank_cnt <= '0;
            an        <= digit_en[active_digit] ? ~(4'b0001 << active_digit) : AN_OFF;
            seg       <= hex_to_seg(hex_in[{active_digit, 2'b00} +: 4]);
            dp        <= ~dp_in[active_digit];
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end
        ST_DRIVE: begin
          // Masked digits still occupy their slot to keep brightness uniform.
          if (tick) begin
            state        <= ST_BLANK;
            active_digit <= active_digit + 2'd1;
            an           <= AN_OFF;
            seg          <= SEG_BLANK;
            dp           <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes a 4-digit common-anode seven-segment display on the Spartan 3E board from the 50 MHz board clock.
- Contains its own scan-rate divider, which generates a per-digit dwell tick.
- Sequences the anodes with a blanking gap between digits to suppress ghosting.
- Decodes 4-bit hex nibbles to active-low segments. Sits between the register/datapath debug outputs and the board display pins.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- SCAN_HZ, 500, per-digit dwell rate. DIV = CLK_HZ/SCAN_HZ; DIV must be ≥ BLANK_CYCLES+2.
- BLANK_CYCLES, 16, clock cycles with all anodes off after each digit change. Must be ≥ 1.

Ports:
- clk_in  input  1  board clock, 50 MHz
- rst  input  1  synchronous, active-low reset
- en  input  1  display enable; low blanks the display and parks the scanner
- hex_in  input  16  four nibbles; digit k = hex_in[4k+3:4k], digit 0 rightmost
- dp_in  input  4  decimal point per digit, 1 = lit
- digit_en  input  4  per-digit enable mask, 1 = shown
- an  output  4  anodes, active-low, registered
- seg  output  7  {g,f,e,d,c,b,a}, active-low, registered
- dp  output  1  decimal point, active-low, registered
- active_digit  output  2  index of the digit slot currently scheduled

Behaviour:
- Reset (rst=0 at a clk_in edge):
  - an=4'b1111, seg=7'h7F, dp=1, active_digit=0.
  - State IDLE; divider count=0; blank count=0.
- Divider:
  - 17-bit-or-wider counter runs 0..DIV-1 while en=1 and state≠IDLE, then wraps to 0.
  - tick=1 for exactly one cycle when count==DIV-1. It is held at 0 in IDLE.
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - Outputs at their reset values.
  - On en=1, go to BLANK next cycle with active_digit=0 and the divider cleared.
- BLANK:
  - an=1111, seg=7'h7F, dp=1.
  - Count BLANK_CYCLES cycles, then go to DRIVE.
  - On the BLANK→DRIVE transition, snapshot hex_in, dp_in and digit_en for active_digit.
- DRIVE:
  - an[active_digit]=0, other bits 1; seg=decode(snapshot nibble); dp=~snapshot dp.
  - If the snapshot digit_en bit is 0, force an=1111 but still consume the full slot, so brightness stays uniform.
  - On tick: active_digit increments mod 4 (3 wraps to 0) and the state goes to BLANK.
- Timing:
  - tick sampled at edge T puts an=1111 from T+1 through T+BLANK_CYCLES.
  - The new digit drives from T+BLANK_CYCLES+1.
  - Full 4-digit frame = 4·DIV cycles (500 Hz dwell → 125 Hz refresh).
- Input changes: hex_in changes mid-dwell do not affect the displayed digit until its next slot. No tearing.
- en=0 in any state:
  - Next cycle → IDLE with outputs at reset values.
  - Divider and active_digit cleared.
- Priority:
  - rst beats en.
  - en=0 beats tick.
  - A tick that coincides with the last BLANK cycle cannot occur, because DIV ≥ BLANK_CYCLES+2.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Shared package holds:
  - the state enum (IDLE/BLANK/DRIVE);
  - the SEG_BLANK=7'h7F and AN_OFF=4'hF constants;
  - the hex-to-segment decode function, reused by other display blocks.
- One sub-module: scan_tick_gen (parameter DIV; ports clk_in, rst, clr, en, tick). It is the divider only.

Test Plan:
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (DIV=10), BLANK_CYCLES=2.
- Reset: hold rst=0 for 3 cycles with en=1 → an=1111, seg=7F, dp=1, active_digit=0 throughout. After release, first digit drive after 2 blank cycles.
- Scan order: hex_in=16'h1234, dp_in=0, digit_en=F →
  - an sequence 1110/1101/1011/0111 with seg 0011001(4), 0110000(3), 0100100(2), 1111001(1).
  - Each digit is followed by exactly 2 cycles of an=1111.
  - Each slot spans 10 cycles total; wrap from digit 3 to digit 0.
- Mid-dwell change: switch hex_in from 16'h0000 to 16'h8888 during digit 0 DRIVE →
  - seg stays 1000000 until the slot ends.
  - Digit 1 shows 0000000.
- Mask/dp: digit_en=4'b0101, dp_in=4'b0001, hex_in=16'hFEDC →
  - Digit 0 shows seg=1000110 with dp=0.
  - Digits 1 and 3 give an=1111 for their full 10-cycle slots.
  - Digit 2 shows 0000110.
- Enable drop: deassert en during digit 2 DRIVE → next cycle an=1111, active_digit=0. Re-enable → scan restarts at digit 0 after 2 blank cycles.
- Reset mid-operation: rst=0 during BLANK of digit 3 → reset values next cycle, with no residual tick.
